// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
//
// Memory access stage between the multi-cycle core and a single-port
// req/ack memory bus. Takes one load or store at a time, performs RV32
// byte/half/word lane steering (byte enables, store-data replication,
// load shift plus sign/zero extension), waits a variable number of cycles
// for the bus acknowledge, and returns a one-cycle response. Misaligned or
// illegal-size requests and bus timeouts are reported through rsp_err_o.
//
// Parameters
//   TIMEOUT_CYCLES : cycles mem_req_o may stay high without mem_ack_i
//                    before the access is aborted with an error.
//
// Ports
//   clk_i          in   clock, rising edge
//   reset_ni       in   asynchronous active-low reset
//   req_valid_i    in   core request valid
//   req_ready_o    out  unit can accept a request (state IDLE)
//   req_we_i       in   1 = store, 0 = load
//   req_addr_i     in   byte address
//   req_size_i     in   00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned_i in   loads: 1 = zero-extend, 0 = sign-extend
//   req_wdata_i    in   store data, right-aligned
//   rsp_valid_o    out  one-cycle response strobe
//   rsp_rdata_o    out  extended load data (0 for stores/errors)
//   rsp_err_o      out  misaligned, illegal size or timeout
//   mem_req_o      out  bus request, high for the whole BUS state
//   mem_we_o       out  bus write
//   mem_addr_o     out  word-aligned bus address
//   mem_be_o       out  byte enables
//   mem_wdata_o    out  lane-replicated store data
//   mem_ack_i      in   bus completion, read data valid this cycle
//   mem_rdata_i    in   bus read word
// ---------------------------------------------------------------------------
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUS  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Wide enough to hold TIMEOUT_CYCLES itself, so the counter may step once
  // past the last legal value without wrapping.
  localparam int unsigned CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;

  // Latched request attributes needed after the bus address has been aligned.
  logic [1:0]    r_off;
  logic [1:0]    r_size;
  logic          r_unsigned;

  // Request decode
  logic          req_bad;
  logic [3:0]    be_calc;
  logic [31:0]   wdata_rep;

  // Load extraction
  logic [31:0]   shifted;
  logic [31:0]   load_data;

  // -------------------------------------------------------------------------
  // Request decode: alignment check, byte enables, store replication
  // -------------------------------------------------------------------------
  always_comb begin
    req_bad = 1'b0;
    unique case (req_size_i)
      SIZE_BYTE: req_bad = 1'b0;
      SIZE_HALF: req_bad = req_addr_i[0];
      SIZE_WORD: req_bad = (req_addr_i[1:0] != 2'b00);
      default:   req_bad = 1'b1;
    endcase
  end

  always_comb begin
    be_calc   = 4'b1111;
    wdata_rep = req_wdata_i;
    unique case (req_size_i)
      SIZE_BYTE: begin
        be_calc   = 4'b0001 << req_addr_i[1:0];
        wdata_rep = {4{req_wdata_i[7:0]}};
      end
      SIZE_HALF: begin
        be_calc   = 4'b0011 << req_addr_i[1:0];
        wdata_rep = {2{req_wdata_i[15:0]}};
      end
      default: begin
        be_calc   = 4'b1111;
        wdata_rep = req_wdata_i;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Load extraction from the bus word using the latched offset/size/sign
  // -------------------------------------------------------------------------
  always_comb begin
    shifted   = mem_rdata_i >> {r_off, 3'b000};
    load_data = shifted;
    unique case (r_size)
      SIZE_BYTE: load_data = r_unsigned ? {24'h000000, shifted[7:0]}
                                        : {{24{shifted[7]}}, shifted[7:0]};
      SIZE_HALF: load_data = r_unsigned ? {16'h0000, shifted[15:0]}
                                        : {{16{shifted[15]}}, shifted[15:0]};
      default:   load_data = shifted;
    endcase
  end

  // -------------------------------------------------------------------------
  // State decoded outputs. mem_req_o is a pure decode of the state register
  // so an asynchronous reset drops it in the same cycle.
  // -------------------------------------------------------------------------
  assign req_ready_o = (state == IDLE);
  assign mem_req_o   = (state == BUS);
  assign rsp_valid_o = (state == RESP);

  // -------------------------------------------------------------------------
  // Control FSM and registered bus/response fields
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state       <= IDLE;
      cnt         <= '0;
      r_off       <= '0;
      r_size      <= '0;
      r_unsigned  <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_be_o    <= '0;
      mem_wdata_o <= '0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid_i) begin
            if (req_bad) begin
              // Rejected without touching the bus.
              rsp_rdata_o <= '0;
              rsp_err_o   <= 1'b1;
              state       <= RESP;
            end else begin
              r_off       <= req_addr_i[1:0];
              r_size      <= req_size_i;
              r_unsigned  <= req_unsigned_i;
              mem_we_o    <= req_we_i;
              mem_addr_o  <= {req_addr_i[31:2], 2'b00};
              mem_be_o    <= be_calc;
              mem_wdata_o <= wdata_rep;
              cnt         <= '0;
              state       <= BUS;
            end
          end
        end

        BUS: begin
          if (mem_ack_i) begin
            // Ack takes priority over a timeout landing in the same cycle.
            rsp_rdata_o <= mem_we_o ? 32'h0 : load_data;
            rsp_err_o   <= 1'b0;
            state       <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) begin
              rsp_rdata_o <= '0;
              rsp_err_o   <= 1'b1;
              state       <= RESP;
            end
          end
        end

        RESP: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        clk_i = 1'b0;
  logic        reset_ni;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [31:0] req_addr_i;
  logic [1:0]  req_size_i;
  logic        req_unsigned_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;

  int total = 0;
  int bad   = 0;

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i          (clk_i),
    .reset_ni       (reset_ni),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_we_i       (req_we_i),
    .req_addr_i     (req_addr_i),
    .req_size_i     (req_size_i),
    .req_unsigned_i (req_unsigned_i),
    .req_wdata_i    (req_wdata_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_rdata_o    (rsp_rdata_o),
    .rsp_err_o      (rsp_err_o),
    .mem_req_o      (mem_req_o),
    .mem_we_o       (mem_we_o),
    .mem_addr_o     (mem_addr_o),
    .mem_be_o       (mem_be_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_ack_i      (mem_ack_i),
    .mem_rdata_i    (mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                           input logic uns, input logic [31:0] wdata);
    req_valid_i    = 1'b1;
    req_we_i       = we;
    req_addr_i     = addr;
    req_size_i     = size;
    req_unsigned_i = uns;
    req_wdata_i    = wdata;
  endtask

  // Legal access; ack is raised in BUS cycle 'lat' (mem_req_o rises in cycle 1).
  task automatic access(input string tag, input logic we, input logic [31:0] addr,
                        input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                        input int lat, input logic [31:0] rdata,
                        input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                        input logic [31:0] exp_rdata);
    chk({tag, ".ready"}, {31'b0, req_ready_o}, 32'd1);
    drive_req(we, addr, size, uns, wdata);
    tick();
    req_valid_i = 1'b0;
    for (int i = 1; i <= lat; i++) begin
      chk({tag, ".req"},   {31'b0, mem_req_o},   32'd1);
      chk({tag, ".rdy0"},  {31'b0, req_ready_o}, 32'd0);
      chk({tag, ".rspv0"}, {31'b0, rsp_valid_o}, 32'd0);
      if (i == 1) begin
        chk({tag, ".we"},    {31'b0, mem_we_o},  {31'b0, we});
        chk({tag, ".addr"},  mem_addr_o,         {addr[31:2], 2'b00});
        chk({tag, ".be"},    {28'b0, mem_be_o},  {28'b0, exp_be});
        if (we) chk({tag, ".wdata"}, mem_wdata_o, exp_wdata);
      end
      if (i == lat) begin
        mem_ack_i   = 1'b1;
        mem_rdata_i = rdata;
      end
      tick();
    end
    mem_ack_i   = 1'b0;
    mem_rdata_i = 32'h5A5A_5A5A;
    chk({tag, ".rspv"},  {31'b0, rsp_valid_o}, 32'd1);
    chk({tag, ".rdata"}, rsp_rdata_o,          exp_rdata);
    chk({tag, ".err"},   {31'b0, rsp_err_o},   32'd0);
    chk({tag, ".reqlo"}, {31'b0, mem_req_o},   32'd0);
    tick();
    chk({tag, ".rspv1"}, {31'b0, rsp_valid_o}, 32'd0);
    chk({tag, ".hold"},  rsp_rdata_o,          exp_rdata);
  endtask

  // Request rejected at accept: response in cycle 1, never a bus request.
  task automatic reject(input string tag, input logic [31:0] addr, input logic [1:0] size);
    drive_req(1'b0, addr, size, 1'b0, 32'h0);
    tick();
    req_valid_i = 1'b0;
    chk({tag, ".req"},   {31'b0, mem_req_o},   32'd0);
    chk({tag, ".rspv"},  {31'b0, rsp_valid_o}, 32'd1);
    chk({tag, ".err"},   {31'b0, rsp_err_o},   32'd1);
    chk({tag, ".rdata"}, rsp_rdata_o,          32'd0);
    tick();
    chk({tag, ".req2"},  {31'b0, mem_req_o},   32'd0);
    chk({tag, ".rspv1"}, {31'b0, rsp_valid_o}, 32'd0);
  endtask

  initial begin
    logic [31:0] b2b_data [3];
    b2b_data[0] = 32'h1111_2222;
    b2b_data[1] = 32'h8765_4321;
    b2b_data[2] = 32'h0BAD_F00D;

    reset_ni       = 1'b0;
    req_valid_i    = 1'b0;
    req_we_i       = 1'b0;
    req_addr_i     = 32'h0;
    req_size_i     = 2'b00;
    req_unsigned_i = 1'b0;
    req_wdata_i    = 32'h0;
    mem_ack_i      = 1'b0;
    mem_rdata_i    = 32'h0;

    #12;
    chk("rst.ready", {31'b0, req_ready_o}, 32'd1);
    chk("rst.req",   {31'b0, mem_req_o},   32'd0);
    chk("rst.rspv",  {31'b0, rsp_valid_o}, 32'd0);
    chk("rst.rdata", rsp_rdata_o,          32'd0);
    chk("rst.err",   {31'b0, rsp_err_o},   32'd0);
    chk("rst.addr",  mem_addr_o,           32'd0);
    chk("rst.be",    {28'b0, mem_be_o},    32'd0);
    chk("rst.wdata", mem_wdata_o,          32'd0);
    reset_ni = 1'b1;
    tick();

    // Loads: byte signed/unsigned, half signed/unsigned, word
    access("lb",  1'b0, 32'h0000_1003, 2'b00, 1'b0, 32'h0, 3, 32'h80FF_1234, 4'b1000, 32'h0, 32'hFFFF_FF80);
    access("lbu", 1'b0, 32'h0000_1003, 2'b00, 1'b1, 32'h0, 3, 32'h80FF_1234, 4'b1000, 32'h0, 32'h0000_0080);
    access("lh",  1'b0, 32'h0000_7000, 2'b01, 1'b0, 32'h0, 1, 32'h1234_F00F, 4'b0011, 32'h0, 32'hFFFF_F00F);
    access("lhu", 1'b0, 32'h0000_7002, 2'b01, 1'b1, 32'h0, 2, 32'h8001_7777, 4'b1100, 32'h0, 32'h0000_8001);
    access("lw",  1'b0, 32'h0000_7104, 2'b10, 1'b0, 32'h0, 1, 32'hC001_D00D, 4'b1111, 32'h0, 32'hC001_D00D);

    // Stores
    access("sh", 1'b1, 32'h0000_2002, 2'b01, 1'b0, 32'hDEAD_BEEF, 1, 32'hFFFF_FFFF, 4'b1100, 32'hBEEF_BEEF, 32'h0);
    access("sb", 1'b1, 32'h0000_8001, 2'b00, 1'b0, 32'h1234_56A5, 2, 32'hFFFF_FFFF, 4'b0010, 32'hA5A5_A5A5, 32'h0);
    access("sw", 1'b1, 32'h0000_9000, 2'b10, 1'b0, 32'h0102_0304, 1, 32'hFFFF_FFFF, 4'b1111, 32'h0102_0304, 32'h0);

    // Rejected requests
    reject("lw_mis", 32'h0000_3001, 2'b10);
    reject("sz11",   32'h0000_3000, 2'b11);
    reject("lh_mis", 32'h0000_3003, 2'b01);

    // Timeout: mem_req_o high in cycles 1..4, error response in cycle 5
    drive_req(1'b0, 32'h0000_A000, 2'b10, 1'b0, 32'h0);
    tick();
    req_valid_i = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      chk("to.req", {31'b0, mem_req_o}, 32'd1);
      tick();
    end
    chk("to.reqlo", {31'b0, mem_req_o},   32'd0);
    chk("to.rspv",  {31'b0, rsp_valid_o}, 32'd1);
    chk("to.err",   {31'b0, rsp_err_o},   32'd1);
    chk("to.rdata", rsp_rdata_o,          32'd0);
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'h7777_7777;
    tick();
    chk("to.late1", {31'b0, rsp_valid_o}, 32'd0);
    chk("to.lreq",  {31'b0, mem_req_o},   32'd0);
    tick();
    mem_ack_i = 1'b0;
    chk("to.late2", {31'b0, rsp_valid_o}, 32'd0);
    chk("to.lerr",  {31'b0, rsp_err_o},   32'd1);
    chk("to.ldata", rsp_rdata_o,          32'd0);

    // Back-to-back: request held valid, ack always high
    drive_req(1'b0, 32'h0000_4000, 2'b10, 1'b0, 32'h0);
    mem_ack_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("b2b.ready", {31'b0, req_ready_o}, 32'd1);
      chk("b2b.idle",  {31'b0, mem_req_o},   32'd0);
      tick();
      chk("b2b.busrdy", {31'b0, req_ready_o}, 32'd0);
      chk("b2b.req",    {31'b0, mem_req_o},   32'd1);
      mem_rdata_i = b2b_data[k];
      tick();
      chk("b2b.rsprdy", {31'b0, req_ready_o}, 32'd0);
      chk("b2b.rspv",   {31'b0, rsp_valid_o}, 32'd1);
      chk("b2b.rdata",  rsp_rdata_o,          b2b_data[k]);
      chk("b2b.err",    {31'b0, rsp_err_o},   32'd0);
      tick();
    end
    req_valid_i = 1'b0;
    mem_ack_i   = 1'b0;
    tick();

    // Reset mid-BUS
    drive_req(1'b0, 32'h0000_5000, 2'b10, 1'b0, 32'h0);
    tick();
    req_valid_i = 1'b0;
    chk("rb.req", {31'b0, mem_req_o}, 32'd1);
    tick();
    reset_ni = 1'b0;
    #1;
    chk("rb.reqlo", {31'b0, mem_req_o},   32'd0);
    chk("rb.ready", {31'b0, req_ready_o}, 32'd1);
    chk("rb.rspv",  {31'b0, rsp_valid_o}, 32'd0);
    chk("rb.addr",  mem_addr_o,           32'd0);
    chk("rb.be",    {28'b0, mem_be_o},    32'd0);
    chk("rb.rdata", rsp_rdata_o,          32'd0);
    #1;
    reset_ni = 1'b1;
    tick();
    chk("rb.norsp", {31'b0, rsp_valid_o}, 32'd0);
    access("rb.lw", 1'b0, 32'h0000_6004, 2'b10, 1'b0, 32'h0, 1, 32'hCAFE_F00D, 4'b1111, 32'h0, 32'hCAFE_F00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory access stage sitting between the multi-cycle control/datapath and the single-port memory bus.
- Accepts one load or store request at a time from the core.
- Performs RV32 byte/half/word lane steering: byte enables, store-data replication, load shift plus sign/zero extension.
- Drives a req/ack bus with variable latency and returns a one-cycle response; misaligned accesses and bus timeouts are reported as errors.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles mem_req_o stays high without mem_ack_i before the access is aborted with error.

Ports:
- clk_i  in  1  clock, rising edge
- reset_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  core request valid
- req_ready_o  out  1  unit can accept a request this cycle
- req_we_i  in  1  1 = store, 0 = load
- req_addr_i  in  32  byte address
- req_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned_i  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_wdata_i  in  32  store data, right-aligned
- rsp_valid_o  out  1  one-cycle response strobe
- rsp_rdata_o  out  32  extended load data; 0 for stores and errors
- rsp_err_o  out  1  misaligned, illegal size or timeout; valid with rsp_valid_o
- mem_req_o  out  1  bus request, held until ack or timeout
- mem_we_o  out  1  bus write
- mem_addr_o  out  32  word address {addr[31:2],2'b00}
- mem_be_o  out  4  byte enables
- mem_wdata_o  out  32  lane-replicated store data
- mem_ack_i  in  1  bus completion; read data valid this cycle
- mem_rdata_i  in  32  bus read word

Behaviour:
- Clock/reset: single clock; reset_ni asynchronous active-low.
- Reset values:
  - State IDLE; timeout counter 0.
  - mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o = 0.
  - rsp_valid_o, rsp_rdata_o, rsp_err_o = 0.
  - req_ready_o = 1, since it is decoded as state==IDLE.
- States: IDLE, BUS, RESP.
- IDLE:
  - req_ready_o=1. Accept when req_valid_i.
  - Misaligned or illegal request goes to RESP with err=1 and no bus access. Misaligned/illegal means: size 11; half with addr[0]=1; word with addr[1:0]!=0.
  - Legal request latches we, address, size, unsigned, be and wdata into registers, then goes to BUS.
- BUS:
  - mem_req_o=1; mem_* outputs come from registers and stay stable for the whole state.
  - Counter increments every cycle without ack.
  - mem_ack_i=1: capture result (load: extracted data; store: 0), err=0, go to RESP. Ack wins over timeout in the same cycle.
  - Counter==TIMEOUT_CYCLES-1 with no ack: go to RESP with err=1, rdata=0.
  - mem_req_o drops on BUS exit.
- RESP: rsp_valid_o=1 for exactly one cycle, then IDLE. rsp_rdata_o/rsp_err_o are registered and hold their value until the next response.
- Byte enables (shifted by addr[1:0]):
  - byte: 0001<<addr[1:0]
  - half: 0011<<addr[1:0]
  - word: 1111
- Store data replication:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: as-is
- Load extraction:
  - shifted = mem_rdata_i >> (8*addr[1:0]).
  - byte: extend shifted[7:0]; half: extend shifted[15:0]; word: shifted.
  - Extension is sign-extend unless req_unsigned_i, in which case zero-extend.
- Latency and throughput:
  - Accept in cycle 0, mem_req_o high from cycle 1.
  - Ack in cycle N (N≥1) gives rsp_valid_o in cycle N+1.
  - Error on accept gives rsp_valid_o in cycle 1.
  - Peak throughput is one access per 3 cycles; no request is accepted during BUS or RESP.
- Other rules:
  - mem_ack_i outside BUS is ignored.
  - req_* inputs are ignored outside IDLE.
  - Reset asserted in BUS drops mem_req_o immediately (asynchronously) and abandons the access with no response.

Test Plan:
- LB, addr 0x1003, unsigned=0, memory word 0x80FF_1234, ack after 2 cycles -> mem_addr_o=0x1000, mem_be_o=1000, rsp_rdata_o=0xFFFF_FF80, rsp_err_o=0, rsp_valid_o 3 cycles after mem_req_o rise; repeat with LBU -> 0x0000_0080.
- SH, addr 0x2002, wdata 0xDEAD_BEEF -> mem_we_o=1, mem_be_o=1100, mem_wdata_o=0xBEEF_BEEF, rsp_rdata_o=0, err=0.
- LW addr 0x3001 and size=11 -> no mem_req_o ever, rsp_valid_o next cycle with err=1, rdata=0.
- Legal LW with mem_ack_i never asserted, TIMEOUT_CYCLES=4 -> mem_req_o high exactly 4 cycles, then rsp_valid_o with err=1; ack arriving afterwards is ignored.
- Back-to-back requests held valid with ack in the first BUS cycle -> accepts spaced exactly 3 cycles apart, req_ready_o low in BUS/RESP, each response correct.
- reset_ni pulled low mid-BUS -> mem_req_o and all outputs 0 the same cycle; after release req_ready_o=1 and a fresh LW completes normally.
